twi_agu_ctrl: RTL and testbench

//  Address/stage sequencer for the radix-16 twiddle datapath.
//  - After a start pulse, walks every butterfly group of every FFT stage.
//  - Issues bank number (BN), memory address (MA), stage index and twiddle exponent base to the BN/MA/twiddle pipeline.
//  - Waits for that pipeline to drain, then reports completion.
//  - Sits between the top-level FFT control and the twiddle/BN/MA pipeline stage.

---
 rtl/twi_agu_ctrl_if.sv | 26 ++
 rtl/twi_agu_ctrl.sv | 127 ++++++++++++
 tb/tb_twi_agu_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/twi_agu_ctrl_if.sv
// Handshake and output bundle between the FFT control, the twiddle address
// sequencer and the BN/MA/twiddle pipeline stage.
interface twi_agu_ctrl_if #(
    parameter int A_WIDTH   = 11,
    parameter int STG_WIDTH = 2
);
    logic                 start;
    logic                 stall;
    logic                 busy;
    logic                 valid;
    logic                 BN_out;
    logic [A_WIDTH-1:0]   MA_out;
    logic [STG_WIDTH-1:0] stage_out;
    logic [A_WIDTH:0]     tw_exp;
    logic                 done;

    modport master (
        output start, stall,
        input  busy, valid, BN_out, MA_out, stage_out, tw_exp, done
    );

    modport slave (
        input  start, stall,
        output busy, valid, BN_out, MA_out, stage_out, tw_exp, done
    );
endinterface

// File: rtl/twi_agu_ctrl.sv
// Radix-16 twiddle address sequencer: walks every butterfly group of every
// stage, emits BN/MA/stage/twiddle base, waits out the pipeline, pulses done.
module twi_agu_ctrl #(
    parameter int A_WIDTH   = 11,
    parameter int STAGES    = 4,
    parameter int STG_WIDTH = 2,
    parameter int DRAIN_CYC = 5
) (
    input  logic          clk,
    input  logic          rst,
    twi_agu_ctrl_if.slave bus
);
    localparam int G     = A_WIDTH + 1;
    localparam int CNT_W = $clog2(DRAIN_CYC + 1);

    localparam logic [G-1:0]         G_LAST    = '1;
    localparam logic [STG_WIDTH-1:0] S_LAST    = STG_WIDTH'(STAGES - 1);
    // The counter is cleared on the last-valid edge, so done lands
    // DRAIN_CYC+1 edges after the final group leaves.
    localparam logic [CNT_W-1:0]     DRAIN_END = CNT_W'(DRAIN_CYC);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t               state, state_d;
    logic [G-1:0]         g, g_d;
    logic [STG_WIDTH-1:0] s, s_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic                 busy, busy_d;
    logic                 valid, valid_d;
    logic                 done, done_d;
    logic                 bn, bn_d;
    logic [A_WIDTH-1:0]   ma, ma_d;
    logic [STG_WIDTH-1:0] stg, stg_d;
    logic [G-1:0]         tw, tw_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d = state;
        g_d     = g;
        s_d     = s;
        cnt_d   = cnt;
        busy_d  = busy;
        valid_d = 1'b0;
        done_d  = 1'b0;
        bn_d    = bn;
        ma_d    = ma;
        stg_d   = stg;
        tw_d    = tw;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    g_d     = '0;
                    s_d     = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    valid_d = 1'b1;
                    bn_d    = ^g;
                    ma_d    = g[G-1:1];
                    stg_d   = s;
                    tw_d    = g << {s, 2'b00};
                    if (g != G_LAST) begin
                        g_d = g + 1'b1;
                    end else if (s != S_LAST) begin
                        g_d = '0;
                        s_d = s + 1'b1;
                    end else begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_END) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            g     <= '0;
            s     <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
            done  <= 1'b0;
            bn    <= 1'b0;
            ma    <= '0;
            stg   <= '0;
            tw    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_d;
            g     <= g_d;
            s     <= s_d;
            cnt   <= cnt_d;
            busy  <= busy_d;
            valid <= valid_d;
            done  <= done_d;
            bn    <= bn_d;
            ma    <= ma_d;
            stg   <= stg_d;
            tw    <= tw_d;
        end
    end

    assign bus.busy      = busy;
    assign bus.valid     = valid;
    assign bus.done      = done;
    assign bus.BN_out    = bn;
    assign bus.MA_out    = ma;
    assign bus.stage_out = stg;
    assign bus.tw_exp    = tw;
endmodule

// File: tb/tb_twi_agu_ctrl.sv
// Self-checking bench for twi_agu_ctrl: directed and randomly stalled full
// transforms compared against an index-based reference model.
module tb_twi_agu_ctrl;
    localparam int A_WIDTH   = 11;
    localparam int STAGES    = 4;
    localparam int STG_WIDTH = 2;
    localparam int DRAIN_CYC = 5;
    localparam int G         = A_WIDTH + 1;
    localparam int NG        = 1 << G;
    localparam int TOTAL     = STAGES * NG;
    localparam int BUDGET    = 40000;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    twi_agu_ctrl_if #(.A_WIDTH(A_WIDTH), .STG_WIDTH(STG_WIDTH)) bus ();

    twi_agu_ctrl #(
        .A_WIDTH(A_WIDTH), .STAGES(STAGES), .STG_WIDTH(STG_WIDTH), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Results of the most recent run_transform call.
    int r_accept_err, r_vcount, r_seq_err, r_bad_idx, r_hold_err, r_busy_err;
    int r_first_valid, r_last_valid, r_stall_cnt, r_done_cyc, r_done_cnt, r_timeout;
    int sp_bn[4], sp_ma[4], sp_st[4], sp_tw[4];

    // Reference: transform index k covers stage k/2^G, group k mod 2^G.
    task automatic model(input int idx, output logic e_bn, output logic [A_WIDTH-1:0] e_ma,
                         output logic [STG_WIDTH-1:0] e_st, output logic [G-1:0] e_tw);
        int grp, stg;
        grp  = idx % NG;
        stg  = idx / NG;
        e_bn = ($countones(grp) % 2) == 1;
        e_ma = A_WIDTH'(grp / 2);
        e_st = STG_WIDTH'(stg);
        e_tw = G'((grp * (16 ** stg)) % NG);
    endtask

    task automatic run_transform(input bit rand_mode);
        int cyc, post, stalls_directed;
        logic e_bn;
        logic [A_WIDTH-1:0] e_ma;
        logic [STG_WIDTH-1:0] e_st;
        logic [G-1:0] e_tw;
        logic l_bn;
        logic [A_WIDTH-1:0] l_ma;
        logic [STG_WIDTH-1:0] l_st;
        logic [G-1:0] l_tw;
        r_accept_err = 0; r_vcount = 0; r_seq_err = 0; r_bad_idx = -1; r_hold_err = 0;
        r_busy_err = 0; r_first_valid = -1; r_last_valid = -1; r_stall_cnt = 0;
        r_done_cyc = -1; r_done_cnt = 0; r_timeout = 0;
        stalls_directed = 0; post = 0; cyc = 0;
        l_bn = 0; l_ma = '0; l_st = '0; l_tw = '0;

        bus.start = 1'b1;
        bus.stall = 1'b0;
        @(negedge clk);
        if (bus.busy !== 1'b1 || bus.valid !== 1'b0) r_accept_err = 1;

        while (post < 10 && r_timeout == 0) begin
            bus.start = 1'b0;
            bus.stall = 1'b0;
            if (r_vcount < TOTAL) begin
                if (rand_mode) bus.stall = 1'($urandom_range(0, 1));
                else if (r_vcount == NG - 1 && stalls_directed < 3) begin
                    bus.stall = 1'b1;
                    stalls_directed++;
                end else if (r_vcount == 5000) bus.start = 1'b1;
                if (bus.stall) r_stall_cnt++;
            end else if (rand_mode) begin
                bus.stall = 1'($urandom_range(0, 1));
            end
            if (!rand_mode && bus.done === 1'b1) bus.start = 1'b1;

            @(negedge clk);
            cyc++;
            if (bus.valid === 1'b1) begin
                model(r_vcount, e_bn, e_ma, e_st, e_tw);
                if ((bus.BN_out !== e_bn || bus.MA_out !== e_ma || bus.stage_out !== e_st ||
                     bus.tw_exp !== e_tw) && r_vcount < TOTAL) begin
                    r_seq_err++;
                    if (r_bad_idx < 0) r_bad_idx = r_vcount;
                end
                case (r_vcount)
                    3:          begin sp_bn[0] = int'(bus.BN_out); sp_ma[0] = int'(bus.MA_out); sp_st[0] = int'(bus.stage_out); sp_tw[0] = int'(bus.tw_exp); end
                    NG + 6:     begin sp_bn[1] = int'(bus.BN_out); sp_ma[1] = int'(bus.MA_out); sp_st[1] = int'(bus.stage_out); sp_tw[1] = int'(bus.tw_exp); end
                    2 * NG + 7: begin sp_bn[2] = int'(bus.BN_out); sp_ma[2] = int'(bus.MA_out); sp_st[2] = int'(bus.stage_out); sp_tw[2] = int'(bus.tw_exp); end
                    TOTAL - 1:  begin sp_bn[3] = int'(bus.BN_out); sp_ma[3] = int'(bus.MA_out); sp_st[3] = int'(bus.stage_out); sp_tw[3] = int'(bus.tw_exp); end
                    default: ;
                endcase
                l_bn = bus.BN_out; l_ma = bus.MA_out; l_st = bus.stage_out; l_tw = bus.tw_exp;
                if (r_first_valid < 0) r_first_valid = cyc;
                r_last_valid = cyc;
                r_vcount++;
            end else if (bus.valid !== 1'b0) begin
                r_seq_err++;
            end else if (r_vcount > 0 && (bus.BN_out !== l_bn || bus.MA_out !== l_ma ||
                                          bus.stage_out !== l_st || bus.tw_exp !== l_tw)) begin
                r_hold_err++;
            end
            if (bus.done === 1'b1) begin
                r_done_cnt++;
                if (r_done_cyc < 0) r_done_cyc = cyc;
            end
            if (r_done_cnt == 0 && bus.busy !== 1'b1) r_busy_err++;
            if (r_done_cnt > 0 && bus.busy !== 1'b0) r_busy_err++;
            if (r_done_cnt > 0) post++;
            if (cyc > BUDGET) r_timeout = 1;
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.busy, bus.valid, bus.done, bus.BN_out} !== 4'b0000) begin
            $display("FAIL reset_ctrl: busy/valid/done/bn=%b expected 0000",
                     {bus.busy, bus.valid, bus.done, bus.BN_out});
        end else passed++;
        total++;
        if ({bus.MA_out, bus.stage_out, bus.tw_exp} !== '0) begin
            $display("FAIL reset_data: ma=%0d stage=%0d tw=%0d expected 0",
                     bus.MA_out, bus.stage_out, bus.tw_exp);
        end else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int vc, n, idle_err;
        vc = 0; n = 0; idle_err = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (vc < 100 && n < 1000) begin
            @(negedge clk);
            n++;
            if (bus.valid === 1'b1) vc++;
        end
        total++;
        if (vc != 100) $display("FAIL mid_run_reach: valids=%0d expected 100", vc);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({bus.busy, bus.valid, bus.done, bus.BN_out, bus.MA_out, bus.stage_out, bus.tw_exp} !== '0) begin
            $display("FAIL mid_run_async_clear: busy=%b valid=%b ma=%0d tw=%0d expected all 0",
                     bus.busy, bus.valid, bus.MA_out, bus.tw_exp);
        end else passed++;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.done !== 1'b0) idle_err++;
        end
        total++;
        if (idle_err != 0) $display("FAIL mid_run_no_resume: active cycles=%0d expected 0", idle_err);
        else passed++;
    endtask

    task automatic test_directed_run();
        run_transform(1'b0);
        total++;
        if (r_timeout != 0) $display("FAIL dir_timeout: no done within %0d cycles", BUDGET);
        else passed++;
        total++;
        if (r_accept_err != 0) $display("FAIL dir_accept: busy/valid wrong after start edge");
        else passed++;
        total++;
        if (r_first_valid != 1) $display("FAIL dir_first_valid: cycle=%0d expected 1", r_first_valid);
        else passed++;
        total++;
        if (r_vcount != TOTAL) $display("FAIL dir_valid_count: got %0d expected %0d", r_vcount, TOTAL);
        else passed++;
        total++;
        if (r_seq_err != 0) $display("FAIL dir_sequence: %0d bad, first at index %0d", r_seq_err, r_bad_idx);
        else passed++;
        total++;
        if (r_stall_cnt != 3 || r_last_valid != TOTAL + 3)
            $display("FAIL dir_stall_window: stalls=%0d last_valid=%0d expected 3 and %0d",
                     r_stall_cnt, r_last_valid, TOTAL + 3);
        else passed++;
        total++;
        if (r_hold_err != 0) $display("FAIL dir_hold: %0d cycles changed while valid=0, expected 0", r_hold_err);
        else passed++;
        total++;
        if (r_done_cyc != r_last_valid + DRAIN_CYC + 1)
            $display("FAIL dir_done_latency: done at %0d expected %0d", r_done_cyc, r_last_valid + DRAIN_CYC + 1);
        else passed++;
        total++;
        if (r_done_cnt != 1) $display("FAIL dir_done_count: got %0d expected 1", r_done_cnt);
        else passed++;
        total++;
        if (r_busy_err != 0) $display("FAIL dir_busy: %0d bad busy cycles expected 0", r_busy_err);
        else passed++;
    endtask

    task automatic test_spot_values();
        int e_bn[4] = '{0, 0, 1, 0};
        int e_ma[4] = '{1, 3, 3, 2047};
        int e_st[4] = '{0, 1, 2, 3};
        int e_tw[4] = '{3, 96, 1792, 0};
        for (int k = 0; k < 4; k++) begin
            total++;
            if (sp_bn[k] != e_bn[k] || sp_ma[k] != e_ma[k] || sp_st[k] != e_st[k] || sp_tw[k] != e_tw[k])
                $display("FAIL spot_%0d: bn=%0d ma=%0d s=%0d tw=%0d expected bn=%0d ma=%0d s=%0d tw=%0d",
                         k, sp_bn[k], sp_ma[k], sp_st[k], sp_tw[k], e_bn[k], e_ma[k], e_st[k], e_tw[k]);
            else passed++;
        end
    endtask

    task automatic test_random_stall();
        run_transform(1'b1);
        total++;
        if (r_timeout != 0) $display("FAIL rnd_timeout: no done within %0d cycles", BUDGET);
        else passed++;
        total++;
        if (r_vcount != TOTAL) $display("FAIL rnd_valid_count: got %0d expected %0d", r_vcount, TOTAL);
        else passed++;
        total++;
        if (r_seq_err != 0) $display("FAIL rnd_sequence: %0d bad, first at index %0d", r_seq_err, r_bad_idx);
        else passed++;
        total++;
        if (r_last_valid != TOTAL + r_stall_cnt)
            $display("FAIL rnd_stall_gaps: last_valid=%0d expected %0d", r_last_valid, TOTAL + r_stall_cnt);
        else passed++;
        total++;
        if (r_hold_err != 0) $display("FAIL rnd_hold: %0d cycles changed while valid=0, expected 0", r_hold_err);
        else passed++;
        total++;
        if (r_done_cyc != r_last_valid + DRAIN_CYC + 1 || r_done_cnt != 1)
            $display("FAIL rnd_done: at %0d count %0d expected at %0d count 1",
                     r_done_cyc, r_done_cnt, r_last_valid + DRAIN_CYC + 1);
        else passed++;
        total++;
        if (r_busy_err != 0) $display("FAIL rnd_busy: %0d bad busy cycles expected 0", r_busy_err);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_directed_run();
        test_spot_values();
        test_random_stall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
